// File: rtl/mrd_source_fmt.sv
// -----------------------------------------------------------------------------
// mrd_source_fmt
//
// Output formatter behind the memory top's source stage. It takes the
// frame-delimited DFT result stream (wIn bits per component) and produces the
// external wOut-bit stream. Each frame gets its own right shift with rounding
// (half toward +inf) and output saturation. Frame length is checked against
// the latched dftpts so the downstream side always sees sop ... eop framing.
//
// Pipeline: input decode + rounding -> stage 1 registers,
//           saturation + flag accumulation -> stage 2 (output) registers.
// Every output is exactly 2 cycles behind the input sample it belongs to.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid, in_sop, in_eop      input framing (sop/eop qualified by valid)
//   in_real, in_imag   [wIn]      input sample, two's complement
//   in_dftpts          [12]       frame length, sampled on an accepted sop
//   shift              [4]        right shift 0..12 (13..15 act as 12),
//                                 sampled on an accepted sop
//   out_valid, out_sop, out_eop   output framing
//   out_real, out_imag [wOut]     rounded and saturated sample
//   out_dftpts         [12]       frame length of the current output frame
//   sat_flag                      with out_eop: some component of the frame
//                                 was clamped
//   frame_err                     one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module mrd_source_fmt #(
  parameter int wIn  = 30,
  parameter int wOut = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic signed [wIn-1:0]  in_real,
  input  logic signed [wIn-1:0]  in_imag,
  input  logic        [11:0]     in_dftpts,
  input  logic        [3:0]      shift,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic signed [wOut-1:0] out_real,
  output logic signed [wOut-1:0] out_imag,
  output logic        [11:0]     out_dftpts,
  output logic                   sat_flag,
  output logic                   frame_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  // Clamp limits expressed in the wIn+1 bit rounding domain.
  localparam logic signed [wIn:0] SAT_MAX = {{(wIn-wOut+2){1'b0}}, {(wOut-1){1'b1}}};
  localparam logic signed [wIn:0] SAT_MIN = {{(wIn-wOut+2){1'b1}}, {(wOut-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Rounding right shift, half toward +inf. One extra bit keeps x + 2^(sh-1)
  // from overflowing for the largest positive input.
  function automatic logic signed [wIn:0] round_shift(
    input logic signed [wIn-1:0] x,
    input logic        [3:0]     sh
  );
    logic signed [wIn:0] xe;
    logic signed [wIn:0] bias;
    logic signed [wIn:0] sum;
    logic signed [wIn:0] res;
    xe = {x[wIn-1], x};
    if (sh == 4'd0) begin
      bias = '0;
      sum  = xe;
      res  = xe;
    end else begin
      bias = {{wIn{1'b0}}, 1'b1} << (sh - 4'd1);
      sum  = xe + bias;
      res  = sum >>> sh;
    end
    return res;
  endfunction

  // Saturate to wOut bits. Returns {clamped, value}.
  function automatic logic [wOut:0] saturate(input logic signed [wIn:0] y);
    logic [wOut:0] res;
    if (y > SAT_MAX) begin
      res = {1'b1, 1'b0, {(wOut-1){1'b1}}};
    end else if (y < SAT_MIN) begin
      res = {1'b1, 1'b1, {(wOut-1){1'b0}}};
    end else begin
      res = {1'b0, y[wOut-1:0]};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame control state
  // ---------------------------------------------------------------------------
  state_t      state_r;
  logic [11:0] cnt_r;
  logic [11:0] dftpts_r;
  logic [3:0]  shift_r;

  state_t      state_next_s;
  logic        new_frame_s;
  logic        emit_s;
  logic        eop_s;
  logic        err_s;
  logic        last_s;
  logic [3:0]  shift_sel_s;
  logic [3:0]  shift_use_s;
  logic [11:0] dftpts_use_s;
  logic [12:0] limit_s;
  logic [12:0] cnt_next_s;

  // Input decode: decide per sample whether it is emitted, ends the frame,
  // or violates framing. A sop sample always uses the freshly presented
  // dftpts/shift; everything else uses the values latched at frame start.
  always_comb begin
    state_next_s = state_r;
    emit_s       = 1'b0;
    eop_s        = 1'b0;
    err_s        = 1'b0;
    new_frame_s  = in_valid & in_sop;

    if (shift > 4'd12) begin
      shift_sel_s = 4'd12;
    end else begin
      shift_sel_s = shift;
    end

    if (new_frame_s) begin
      shift_use_s  = shift_sel_s;
      dftpts_use_s = in_dftpts;
      cnt_next_s   = 13'd1;
    end else begin
      shift_use_s  = shift_r;
      dftpts_use_s = dftpts_r;
      cnt_next_s   = {1'b0, cnt_r} + 13'd1;
    end

    // dftpts==0 stands for a 4096-sample frame; 13-bit compare covers it.
    if (dftpts_use_s == 12'd0) begin
      limit_s = 13'd4096;
    end else begin
      limit_s = {1'b0, dftpts_use_s};
    end
    last_s = (cnt_next_s == limit_s);

    if (in_valid) begin
      if (in_sop) begin
        // Accept (or restart) a frame. A sop inside a frame is always an
        // error; eop without reaching dftpts, or reaching dftpts without
        // eop, is an error in both cases (eop XOR last).
        emit_s = 1'b1;
        eop_s  = in_eop | last_s;
        err_s  = (state_r == FRAME) | (in_eop ^ last_s);
        if (eop_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FRAME;
        end
      end else begin
        case (state_r)
          FRAME: begin
            emit_s = 1'b1;
            eop_s  = in_eop | last_s;
            err_s  = in_eop ^ last_s;
            if (eop_s) begin
              state_next_s = IDLE;
            end else begin
              state_next_s = FRAME;
            end
          end
          IDLE: begin
            // Sample outside any frame: dropped.
            err_s        = 1'b1;
            state_next_s = IDLE;
          end
          default: begin
            err_s        = 1'b1;
            state_next_s = IDLE;
          end
        endcase
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame state machine: state, sample counter and per-frame settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 12'd0;
      dftpts_r <= 12'd0;
      shift_r  <= 4'd0;
    end else begin
      state_r <= state_next_s;
      if (emit_s) begin
        cnt_r <= cnt_next_s[11:0];
      end
      if (new_frame_s) begin
        dftpts_r <= in_dftpts;
        shift_r  <= shift_sel_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: rounded sample plus framing
  // ---------------------------------------------------------------------------
  logic                s1_valid_r;
  logic                s1_sop_r;
  logic                s1_eop_r;
  logic                s1_err_r;
  logic [11:0]         s1_dftpts_r;
  logic signed [wIn:0] s1_real_r;
  logic signed [wIn:0] s1_imag_r;

  // Stage 1 register: rounding result and the decoded framing of the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_sop_r    <= 1'b0;
      s1_eop_r    <= 1'b0;
      s1_err_r    <= 1'b0;
      s1_dftpts_r <= 12'd0;
      s1_real_r   <= '0;
      s1_imag_r   <= '0;
    end else begin
      s1_valid_r  <= emit_s;
      s1_sop_r    <= new_frame_s;
      s1_eop_r    <= eop_s;
      s1_err_r    <= err_s;
      s1_dftpts_r <= dftpts_use_s;
      s1_real_r   <= round_shift(in_real, shift_use_s);
      s1_imag_r   <= round_shift(in_imag, shift_use_s);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturation, frame saturation accumulator, output registers
  // ---------------------------------------------------------------------------
  logic          acc_r;
  logic [wOut:0] sat_real_s;
  logic [wOut:0] sat_imag_s;
  logic          clamp_s;
  logic          acc_eff_s;

  // Clamp both components; a sop sample starts a fresh accumulator so an
  // aborted frame never leaks its saturation into the next one.
  always_comb begin
    sat_real_s = saturate(s1_real_r);
    sat_imag_s = saturate(s1_imag_r);
    clamp_s    = s1_valid_r & (sat_real_s[wOut] | sat_imag_s[wOut]);
    if (s1_sop_r) begin
      acc_eff_s = clamp_s;
    end else begin
      acc_eff_s = acc_r | clamp_s;
    end
  end

  // Output register stage; data is zero whenever out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_dftpts <= 12'd0;
      sat_flag   <= 1'b0;
      frame_err  <= 1'b0;
      acc_r      <= 1'b0;
    end else begin
      out_valid <= s1_valid_r;
      out_sop   <= s1_valid_r & s1_sop_r;
      out_eop   <= s1_valid_r & s1_eop_r;
      sat_flag  <= s1_valid_r & s1_eop_r & acc_eff_s;
      frame_err <= s1_err_r;
      if (s1_valid_r) begin
        out_real   <= sat_real_s[wOut-1:0];
        out_imag   <= sat_imag_s[wOut-1:0];
        out_dftpts <= s1_dftpts_r;
        acc_r      <= acc_eff_s;
      end else begin
        out_real <= '0;
        out_imag <= '0;
      end
    end
  end

endmodule

// File: doc/mrd_source_fmt.md
# mrd_source_fmt

Output formatter that sits directly downstream of the memory top's source stage. It consumes the 30-bit, frame-delimited DFT result stream and produces the 18-bit external output stream. It applies a per-frame programmable right shift with rounding, saturates the result, and polices frame length against `dftpts` so that downstream logic always sees well-formed sop/eop framing.

## Interface
Parameters:
- `wIn`, 30: input sample width per real/imag component, two's complement.
- `wOut`, 18: output sample width per component, two's complement.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample valid.
- `in_sop`  in  1  first sample of frame; qualified by `in_valid`.
- `in_eop`  in  1  last sample of frame; qualified by `in_valid`.
- `in_real`, `in_imag`  in  wIn  input sample.
- `in_dftpts`  in  12  frame length; sampled on an accepted sop.
- `shift`  in  4  right-shift amount (0..12); sampled on an accepted sop.
- `out_valid`, `out_sop`, `out_eop`  out  1  output framing.
- `out_real`, `out_imag`  out  wOut  formatted sample.
- `out_dftpts`  out  12  latched frame length, held for the whole frame.
- `sat_flag`  out  1  high with `out_eop` if any component of the frame saturated.
- `frame_err`  out  1  one-cycle pulse on a framing violation.

## Operation
State machine with two states, IDLE and FRAME. Reset enters IDLE.
- **IDLE**
  - `in_valid & in_sop` is accepted: latch `in_dftpts` and `shift`, clear the sample counter to 1 and the saturation accumulator, emit the sample with `out_sop`=1, then go to FRAME.
  - `in_valid` without sop: drop the sample and pulse `frame_err`.
- **FRAME**, on each `in_valid`:
  - Increment the counter. The counter is 12 bits and never wraps, because the frame terminates at `dftpts`.
  - **eop on the counter==`dftpts` sample:** normal end. Emit `out_eop`, go to IDLE.
  - **eop early:** emit the sample with `out_eop`, pulse `frame_err`, go to IDLE.
  - **counter reaches `dftpts` without eop:** force `out_eop` on that sample, pulse `frame_err`, go to IDLE. Later non-sop samples are dropped per the IDLE rule.
  - **sop mid-frame:** pulse `frame_err` and restart the frame on this sample, exactly as the IDLE accept. The previous frame gets no eop. `sat_flag` is not reported for the aborted frame.
  - **sop and eop together on one sample:** single-sample frame. Legal only if the latched `dftpts`==1; otherwise `frame_err`. Emit both `out_sop` and `out_eop`.
- A sample with `dftpts`==0 latched behaves as `dftpts`==4096 for the forced-eop rule.

Arithmetic, applied to each component independently:
- **Rounding:** shift 0 passes through. Otherwise `y = (x + 2^(shift-1)) >>> shift`, computed in wIn+1 bits so the add cannot overflow. Arithmetic shift, round half toward +inf.
- **Saturation:** clamp y to [-2^(wOut-1), 2^(wOut-1)-1], i.e. [-131072, 131071] for the defaults.
- **Saturation flag:** any clamp sets the frame accumulator. `sat_flag` = accumulator OR the current sample's clamp, presented with `out_eop` only and 0 otherwise.
- **Shift range:** values 13..15 are treated as 12.

## Timing
- Fixed 2-cycle latency from input to every output: stage 1 rounds, stage 2 saturates and registers.
- `out_sop`, `out_eop`, `out_valid`, `sat_flag`, `frame_err` and `out_dftpts` are all aligned to the same output cycle as their sample.
- `frame_err` for a dropped sample also appears 2 cycles after it, with `out_valid`=0.
- No backpressure. Input may be valid every cycle, and gaps in `in_valid` are allowed mid-frame.
- **Reset values:** all outputs 0, state IDLE, counter 0.
  - Reset asserted mid-frame clears the pipeline immediately; no partial eop is emitted.
  - After release, the block waits for a new sop.
- `shift` and `in_dftpts` changes mid-frame have no effect until the next accepted sop.

## Test plan
- **Normal frame:** 1200-sample frame, `dftpts`=1200, shift=0, values within range → 1200 outputs 2 cycles late, sop on first, eop on 1200th, `sat_flag`=0, no `frame_err`.
- **Rounding:**
  - shift=4, in_real=0x18 (24) → 2.
  - in_real=-24 → -1.
  - in_real=7 → 0.
  - in_real=8 → 1.
- **Saturation:** shift=0, in_real=200000, in_imag=-200000 → out_real=131071, out_imag=-131072, `sat_flag`=1 on eop.
- **Early and late eop:**
  - eop on sample 10 with `dftpts`=12 → `out_eop` on sample 10 plus `frame_err`.
  - `dftpts`=12 with no eop → forced eop on sample 12 plus `frame_err`.
  - Sample 13 is then dropped with `frame_err`.
- **sop mid-frame:** new sop at sample 5 of a 12-sample frame → `frame_err` plus `out_sop` on that sample, with the counter restarting.
- **Async reset:** `rst_n` pulsed low during sample 6 → outputs 0 within the reset; no eop; the next frame after release is processed normally.
